// File: rtl/segre_id_issue_queue_pkg.sv
// Shared types and constants for the ID-stage issue queue: the decoded
// instruction record, pipeline selectors and history-file id helpers.
package segre_id_issue_queue_pkg;

    localparam int HF_SIZE   = 6;
    localparam int HF_PTR    = $clog2(HF_SIZE);
    localparam int IQ_DEPTH  = 4;
    localparam int NUM_PIPES = 3;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT
    } alu_opcode_e;

    typedef enum logic [1:0] {
        MEMOP_BYTE, MEMOP_HALF, MEMOP_WORD
    } memop_type_e;

    typedef enum logic [1:0] {
        PIPE_EX  = 2'd0,
        PIPE_MEM = 2'd1,
        PIPE_RVM = 2'd2
    } pipeline_e;

    typedef enum logic [1:0] {
        BYPASS_NONE, BYPASS_EX, BYPASS_MEM, BYPASS_WB
    } bypass_e;

    typedef struct packed {
        alu_opcode_e alu_opcode;
        logic [31:0] alu_src_a;
        logic [31:0] alu_src_b;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        memop_type_e memop_type;
        logic        memop_rd;
        logic        memop_wr;
        logic        memop_sign_ext;
        logic [31:0] memop_rf_data;
        logic [31:0] br_src_a;
        logic [31:0] br_src_b;
        pipeline_e   pipeline;
        bypass_e     bypass_a;
        bypass_e     bypass_b;
        logic        hf_req;
    } id_issue_t;

    // Next history-file id, wrapping at HF_SIZE (which need not be a power of two).
    function automatic logic [HF_PTR-1:0] hf_next(input logic [HF_PTR-1:0] p);
        return (p == HF_PTR'(HF_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/segre_id_issue_queue_if.sv
// Decode-to-issue bus of the ID issue queue. The master side is decode plus
// the stall sources; the slave side is the queue itself.
interface segre_id_issue_queue_if
    import segre_id_issue_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) ();

    logic                         enq_valid_i;
    logic                         enq_ready_o;
    id_issue_t                    enq_instr_i;
    logic                         enq_hf_req_i;
    logic                         dep_stall_i;
    logic [NUM_PIPES-1:0]         pipe_ready_i;
    logic                         hf_full_i;
    logic                         flush_i;
    logic                         issue_valid_o;
    id_issue_t                    issue_instr_o;
    logic [HF_PTR-1:0]            issue_instr_id_o;
    logic                         new_hf_entry_o;
    logic [$clog2(DEPTH+1)-1:0]   count_o;

    modport master (
        output enq_valid_i, enq_instr_i, enq_hf_req_i, dep_stall_i,
               pipe_ready_i, hf_full_i, flush_i,
        input  enq_ready_o, issue_valid_o, issue_instr_o, issue_instr_id_o,
               new_hf_entry_o, count_o
    );

    modport slave (
        input  enq_valid_i, enq_instr_i, enq_hf_req_i, dep_stall_i,
               pipe_ready_i, hf_full_i, flush_i,
        output enq_ready_o, issue_valid_o, issue_instr_o, issue_instr_id_o,
               new_hf_entry_o, count_o
    );

endinterface

// File: rtl/segre_id_issue_queue_circ_ptr.sv
// Wrapping increment counter modulo MOD with synchronous clear; used for the
// queue write/read pointers and the history-file id pointer.
module segre_id_issue_queue_circ_ptr #(
    parameter  int MOD = 4,
    localparam int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk_i,
    input  logic         rsn_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] val_o
);

    // Pointer register: reset/clear to 0, otherwise step and wrap at MOD-1.
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            val_o <= '0;
        end else if (clr_i) begin
            val_o <= '0;
        end else if (inc_i) begin
            val_o <= (val_o == W'(MOD - 1)) ? '0 : val_o + 1'b1;
        end
    end

endmodule

// File: rtl/segre_id_issue_queue.sv
// In-order issue buffer between ID decode and the EX/MEM/RVM pipelines.
// Issues at most one instruction per cycle and hands out history-file ids
// at issue time. Optional build macro SEGRE_IQ_BYPASS_EN enables an
// empty-queue pass-through (0-cycle enqueue-to-issue latency).
module segre_id_issue_queue
    import segre_id_issue_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input logic                    clk_i,
    input logic                    rsn_i,
    segre_id_issue_queue_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    id_issue_t         mem [DEPTH];
    id_issue_t         wr_entry;
    id_issue_t         head;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic [HF_PTR-1:0] hf_ptr_q;
    logic              bypass_act;
    logic              head_valid;
    logic              issue_valid;
    logic              new_hf;
    logic              enq_ready;
    logic              enq_fire;
    logic              wr_en;
    logic              rd_en;

    function automatic logic pipe_ok(input logic [NUM_PIPES-1:0] rdy, input pipeline_e p);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (int'(p) == i) r = rdy[i];
        end
        return r;
    endfunction

`ifdef SEGRE_IQ_BYPASS_EN
    assign bypass_act = (count_q == '0) & bus.enq_valid_i;
`else
    assign bypass_act = 1'b0;
`endif

    // Stored record carries the enqueue-side hf request; head selects the pass-through when active.
    always_comb begin
        wr_entry        = bus.enq_instr_i;
        wr_entry.hf_req = bus.enq_hf_req_i;
        head            = bypass_act ? wr_entry : mem[rd_ptr];
    end

    assign head_valid  = (count_q != '0) | bypass_act;
    assign enq_ready   = rsn_i & (count_q < CW'(DEPTH));
    assign enq_fire    = bus.enq_valid_i & enq_ready & ~bus.flush_i;
    assign issue_valid = rsn_i & head_valid & ~bus.dep_stall_i
                       & pipe_ok(bus.pipe_ready_i, head.pipeline)
                       & ~(head.hf_req & bus.hf_full_i) & ~bus.flush_i;
    assign new_hf      = issue_valid & head.hf_req;
    // A passed-through instruction that issues never occupies a slot.
    assign wr_en       = enq_fire & ~(bypass_act & issue_valid);
    assign rd_en       = issue_valid & (count_q != '0);

    assign bus.enq_ready_o      = enq_ready;
    assign bus.issue_valid_o    = issue_valid;
    assign bus.issue_instr_o    = head;
    assign bus.new_hf_entry_o   = new_hf;
    assign bus.issue_instr_id_o = new_hf ? hf_next(hf_ptr_q) : hf_ptr_q;
    assign bus.count_o          = count_q;

    // Payload storage: written on enqueue only, no reset needed.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= wr_entry;
    end

    // Occupancy: flush empties the queue; otherwise track writes minus issues.
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            count_q <= '0;
        end else if (bus.flush_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    segre_id_issue_queue_circ_ptr #(.MOD(DEPTH)) u_wr_ptr (
        .clk_i (clk_i),
        .rsn_i (rsn_i),
        .clr_i (bus.flush_i),
        .inc_i (wr_en),
        .val_o (wr_ptr)
    );

    segre_id_issue_queue_circ_ptr #(.MOD(DEPTH)) u_rd_ptr (
        .clk_i (clk_i),
        .rsn_i (rsn_i),
        .clr_i (bus.flush_i),
        .inc_i (rd_en),
        .val_o (rd_ptr)
    );

    // History-file pointer survives flushes so ids stay monotonic.
    segre_id_issue_queue_circ_ptr #(.MOD(HF_SIZE)) u_hf_ptr (
        .clk_i (clk_i),
        .rsn_i (rsn_i),
        .clr_i (1'b0),
        .inc_i (new_hf),
        .val_o (hf_ptr_q)
    );

endmodule

// File: tb/tb_segre_id_issue_queue.sv
// Scoreboard bench for segre_id_issue_queue: accepted enqueues are pushed to a
// queue of expected entries and popped when the DUT issues; a small model
// predicts ready/issue/count/hf id every cycle.
module tb_segre_id_issue_queue;
    import segre_id_issue_queue_pkg::*;

    localparam int DEPTH = IQ_DEPTH;

    logic clk = 1'b0;
    logic rsn = 1'b0;
    always #5 clk = ~clk;

    segre_id_issue_queue_if #(.DEPTH(DEPTH)) bus ();

    segre_id_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rsn_i (rsn),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [4:0] tag;
        bit         hf;
        pipeline_e  pipe;
    } exp_t;

    exp_t sb[$];
    int   ids_seen[$];
    int   checks = 0;
    int   errors = 0;
    int   hf_exp = 0;
    int   tag_n  = 0;
    bit   armed  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        bus.enq_valid_i  = 1'b0;
        bus.enq_instr_i  = '0;
        bus.enq_hf_req_i = 1'b0;
        bus.dep_stall_i  = 1'b0;
        bus.pipe_ready_i = '1;
        bus.hf_full_i    = 1'b0;
        bus.flush_i      = 1'b0;
    endtask

    task automatic put(input bit v, input pipeline_e p, input bit hf);
        id_issue_t t;
        t           = '0;
        t.rf_waddr  = 5'(tag_n);
        t.alu_src_a = 32'(tag_n * 3 + 1);
        t.pipeline  = p;
        t.hf_req    = hf;
        bus.enq_valid_i  = v;
        bus.enq_instr_i  = t;
        bus.enq_hf_req_i = hf;
    endtask

    // One cycle: inputs were driven at the falling edge; evaluate model, compare, advance.
    task automatic tick();
        int   n0;
        bit   accept;
        bit   has_head;
        bit   exp_iv;
        exp_t e;
        #2;
        n0 = sb.size();
        if (armed) check_val("count", 32'(bus.count_o), 32'(n0));
        check_val("enq_ready", 32'(bus.enq_ready_o), 32'(rsn && (n0 < DEPTH)));
        accept = rsn && bus.enq_valid_i && !bus.flush_i && (n0 < DEPTH);
        if (accept) begin
            sb.push_back('{tag: bus.enq_instr_i.rf_waddr, hf: bus.enq_hf_req_i,
                           pipe: bus.enq_instr_i.pipeline});
            tag_n++;
        end
`ifdef SEGRE_IQ_BYPASS_EN
        has_head = sb.size() > 0;
`else
        has_head = n0 > 0;
`endif
        exp_iv = 1'b0;
        if (has_head) begin
            e = sb[0];
            check_val("head_tag", 32'(bus.issue_instr_o.rf_waddr), 32'(e.tag));
            exp_iv = rsn && !bus.flush_i && !bus.dep_stall_i
                     && bus.pipe_ready_i[int'(e.pipe)] && !(e.hf && bus.hf_full_i);
        end
        check_val("issue_valid", 32'(bus.issue_valid_o), 32'(exp_iv));
        if (exp_iv && bus.issue_valid_o) begin
            e = sb.pop_front();
            check_val("new_hf", 32'(bus.new_hf_entry_o), 32'(e.hf));
            if (e.hf) hf_exp = (hf_exp + 1) % HF_SIZE;
            check_val("hf_id", 32'(bus.issue_instr_id_o), 32'(hf_exp));
            ids_seen.push_back(int'(bus.issue_instr_id_o));
        end else begin
            check_val("new_hf_idle", 32'(bus.new_hf_entry_o), 32'd0);
        end
        if (bus.flush_i) sb.delete();
        if (!rsn) begin
            sb.delete();
            hf_exp = 0;
            armed  = 1;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        bus.enq_valid_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check_val("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        set_idle();
        rsn = 1'b0;
        tick();
        tick();
        rsn = 1'b1;
    endtask

    initial begin
        int exp1[5];
        int exp3[9];
        int hf_before;
        exp1 = '{1, 2, 3, 4, 5};
        exp3 = '{1, 2, 3, 3, 4, 5, 0, 1, 2};

        @(negedge clk);
        do_reset();
        tick();

        // 1: streaming enqueue/issue, occupancy stays at most 1
        ids_seen.delete();
        for (int i = 0; i < 5; i++) begin
            put(1'b1, PIPE_EX, 1'b1);
            check_val("t1_cnt_le1", 32'(bus.count_o <= 1), 32'd1);
            tick();
        end
        drain();
        check_val("t1_n_ids", 32'(ids_seen.size()), 32'd5);
        foreach (exp1[i]) if (i < ids_seen.size()) check_val("t1_id", 32'(ids_seen[i]), 32'(exp1[i]));

        // 2: fill under dependence stall, full refuses even while head issues
        bus.dep_stall_i = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            put(1'b1, PIPE_MEM, 1'b0);
            tick();
        end
        check_val("t2_full_cnt", 32'(bus.count_o), 32'(DEPTH));
        check_val("t2_full_rdy", 32'(bus.enq_ready_o), 32'd0);
        bus.dep_stall_i = 1'b0;
        put(1'b1, PIPE_MEM, 1'b0);
        tick();
        bus.enq_valid_i = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            check_val("t2_consec", 32'(bus.issue_valid_o), 32'd1);
            tick();
        end
        drain();

        // mid-operation reset with queued entries and an enqueue pending
        bus.dep_stall_i = 1'b1;
        put(1'b1, PIPE_EX, 1'b1);
        tick();
        tick();
        rsn = 1'b0;
        tick();
        rsn = 1'b1;
        set_idle();
        tick();

        // 3: hf id wrap at HF_SIZE, a non-hf entry repeats the previous id
        ids_seen.delete();
        for (int i = 0; i < 9; i++) begin
            put(1'b1, PIPE_EX, (i != 3));
            tick();
        end
        drain();
        check_val("t3_n_ids", 32'(ids_seen.size()), 32'd9);
        foreach (exp3[i]) if (i < ids_seen.size()) check_val("t3_id", 32'(ids_seen[i]), 32'(exp3[i]));

        // 4: flush with three queued and a simultaneous enqueue
        bus.dep_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put(1'b1, PIPE_EX, 1'b1);
            tick();
        end
        hf_before = hf_exp;
        bus.dep_stall_i = 1'b0;
        bus.flush_i = 1'b1;
        put(1'b1, PIPE_EX, 1'b1);
        tick();
        bus.flush_i = 1'b0;
        bus.enq_valid_i = 1'b0;
        check_val("t4_cnt_after", 32'(bus.count_o), 32'd0);
        tick();
        put(1'b1, PIPE_EX, 1'b1);
        tick();
        drain();
        check_val("t4_id_cont", 32'(ids_seen[$]), 32'((hf_before + 1) % HF_SIZE));

        // 5: RVM head blocks the EX entry behind it; then hf_full blocks an hf head
        bus.pipe_ready_i = 3'b011;
        put(1'b1, PIPE_RVM, 1'b1);
        tick();
        put(1'b1, PIPE_EX, 1'b1);
        tick();
        bus.enq_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_val("t5_blocked", 32'(bus.count_o), 32'd2);
        bus.pipe_ready_i = 3'b111;
        check_val("t5_rvm_first", 32'(bus.issue_instr_o.pipeline), 32'(PIPE_RVM));
        drain();
        bus.hf_full_i = 1'b1;
        put(1'b1, PIPE_EX, 1'b1);
        tick();
        put(1'b1, PIPE_EX, 1'b0);
        tick();
        bus.enq_valid_i = 1'b0;
        tick();
        bus.hf_full_i = 1'b0;
        drain();

`ifdef SEGRE_IQ_BYPASS_EN
        // 6: empty-queue pass-through, then a stalled pass-through gets written
        put(1'b1, PIPE_EX, 1'b1);
        #2;
        check_val("t6_same_cycle", 32'(bus.issue_valid_o), 32'd1);
        @(negedge clk);
        bus.enq_valid_i = 1'b0;
        check_val("t6_cnt0", 32'(bus.count_o), 32'd0);
        bus.dep_stall_i = 1'b1;
        put(1'b1, PIPE_EX, 1'b1);
        tick();
        bus.enq_valid_i = 1'b0;
        check_val("t6_cnt1", 32'(bus.count_o), 32'd1);
        bus.dep_stall_i = 1'b0;
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
